aes_round_ctrl: RTL



---
 rtl/aes_round_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 core: initial AddRoundKey, NR external rounds, ciphertext handshake.
// Optional feature macro AES_ROUND_CTRL_ABORT_EN adds an abort input that cancels a block in ROUND or DONE.
module aes_round_ctrl #(
    parameter int NR     = 10,
    parameter int DP_LAT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic                    abort,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out_data,
    output logic [$clog2(NR+1)-1:0] rk_idx,
    input  logic [127:0]            rk_i,
    output logic [127:0]            rd_state,
    output logic                    rd_final,
    input  logic [127:0]            rd_result,
    output logic                    busy
);
    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] LAST_RND = RW'(NR);
    localparam logic [2:0]    WAIT_END = 3'(DP_LAT);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [127:0]  data_q;
    logic [RW-1:0] rnd_q;
    logic [2:0]    wait_q;
    logic          cancel;
    logic          step;
    logic          last;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign cancel = abort && (state != IDLE);
`else
    assign cancel = 1'b0;
`endif

    // A round completes on the cycle the datapath latency has been waited out.
    assign step = (state == ROUND) && (wait_q == WAIT_END);
    assign last = (rnd_q == LAST_RND);

    always_ff @(posedge clk) begin
        if (rst || cancel) begin
            state  <= IDLE;
            data_q <= '0;
            rnd_q  <= '0;
            wait_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data ^ rk_i;
                        rnd_q  <= RW'(1);
                        wait_q <= '0;
                    end
                end
                ROUND: begin
                    if (step) begin
                        data_q <= rd_result;
                        wait_q <= '0;
                        if (!last) begin
                            rnd_q <= rnd_q + 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The state register is the datapath operand and the ciphertext at once.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        rd_final  = (state == ROUND) && last;
        rk_idx    = '0;
        rd_state  = data_q;
        out_data  = data_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                rk_idx = rnd_q;
                if (step && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
